spi_bus_arbiter: RTL and testbench



---
 rtl/spi_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one spi_master between two byte-stream requesters.
// Requester 0 is the mode/config sequencer and requester 1 is the status poller.
// The arbiter owns chip-select. It enforces setup and gap timing around each
// grant, muxes start/data toward the master, and routes byte-complete pulses
// back to the granted requester. A watchdog reclaims the bus from a requester
// that holds it idle for too long.
module spi_bus_arbiter #(
    parameter int SS_SETUP = 2,
    parameter int SS_GAP   = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       lock0,
    input  logic       start0,
    input  logic [7:0] data_in0,
    output logic       gnt0,
    output logic       done0,
    input  logic       req1,
    input  logic       lock1,
    input  logic       start1,
    input  logic [7:0] data_in1,
    output logic       gnt1,
    output logic       done1,
    output logic       m_start,
    output logic [7:0] m_data_in,
    output logic       m_ss,
    input  logic       m_busy,
    input  logic       m_new_data,
    input  logic [7:0] m_data_out,
    output logic [7:0] rd_data,
    output logic       timeout_err
);

    localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
    localparam logic [15:0] GAP_LAST   = 16'(SS_GAP - 1);
    localparam logic [15:0] WD_LAST    = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_ss;
    logic        r_last;
    logic        r_tmo;
    logic [15:0] r_cnt;

    logic        w_gnt0_nxt;
    logic        w_gnt1_nxt;
    logic        w_ss_nxt;
    logic        w_last_nxt;
    logic        w_tmo_nxt;
    logic [15:0] w_cnt_nxt;

    // Request signals of whichever requester currently holds the grant.
    // With no grant these are all 0, so nothing leaks through to the master.
    logic w_req_g;
    logic w_lock_g;
    logic w_start_g;
    logic w_active;
    logic w_idle_cyc;

    assign w_req_g    = (r_gnt0 & req0)   | (r_gnt1 & req1);
    assign w_lock_g   = (r_gnt0 & lock0)  | (r_gnt1 & lock1);
    assign w_start_g  = (r_gnt0 & start0) | (r_gnt1 & start1);
    assign w_active   = (r_state == ACTIVE);
    assign w_idle_cyc = !m_busy && !w_start_g;

    assign m_start     = w_active & w_start_g;
    assign m_data_in   = r_gnt0 ? data_in0 : (r_gnt1 ? data_in1 : 8'h00);
    assign m_ss        = r_ss;
    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign done0       = m_new_data & r_gnt0;
    assign done1       = m_new_data & r_gnt1;
    assign rd_data     = m_data_out;
    assign timeout_err = r_tmo;

    // Register the state, grants, chip-select and the shared cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_ss    <= 1'b1;
            r_last  <= 1'b1;
            r_tmo   <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt0  <= w_gnt0_nxt;
            r_gnt1  <= w_gnt1_nxt;
            r_ss    <= w_ss_nxt;
            r_last  <= w_last_nxt;
            r_tmo   <= w_tmo_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: grant, setup delay, active/watchdog, release gap.
    // r_cnt measures setup time in SETUP, idle time in ACTIVE and gap time in RELEASE.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0_nxt  = r_gnt0;
        w_gnt1_nxt  = r_gnt1;
        w_ss_nxt    = r_ss;
        w_last_nxt  = r_last;
        w_tmo_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                // On a tie, the requester that was not served last wins.
                if (req0 && (!req1 || r_last)) begin
                    w_gnt0_nxt  = 1'b1;
                    w_ss_nxt    = 1'b0;
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = 16'd0;
                end else if (req1) begin
                    w_gnt1_nxt  = 1'b1;
                    w_ss_nxt    = 1'b0;
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = 16'd0;
                end
            end
            SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ACTIVE: begin
                if (!w_lock_g && !w_req_g && w_idle_cyc) begin
                    w_gnt0_nxt  = 1'b0;
                    w_gnt1_nxt  = 1'b0;
                    w_ss_nxt    = 1'b1;
                    w_last_nxt  = r_gnt1;
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = 16'd0;
                end else if (w_idle_cyc) begin
                    if (r_cnt == WD_LAST) begin
                        w_gnt0_nxt  = 1'b0;
                        w_gnt1_nxt  = 1'b0;
                        w_ss_nxt    = 1'b1;
                        w_last_nxt  = r_gnt1;
                        w_tmo_nxt   = 1'b1;
                        w_state_nxt = RELEASE;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end else begin
                    w_cnt_nxt = 16'd0;
                end
            end
            RELEASE: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt0_nxt  = 1'b0;
                w_gnt1_nxt  = 1'b0;
                w_ss_nxt    = 1'b1;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed testbench for spi_bus_arbiter (SS_SETUP=2, SS_GAP=4, TIMEOUT=16).
// The bench plays the role of spi_master itself by driving m_busy and m_new_data.
module tb_spi_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, lock0, start0;
    logic [7:0] data_in0;
    logic       gnt0, done0;
    logic       req1, lock1, start1;
    logic [7:0] data_in1;
    logic       gnt1, done1;
    logic       m_start;
    logic [7:0] m_data_in;
    logic       m_ss;
    logic       m_busy, m_new_data;
    logic [7:0] m_data_out;
    logic [7:0] rd_data;
    logic       timeout_err;

    int n_vec = 0;
    int n_err = 0;
    int n;

    spi_bus_arbiter #(.SS_SETUP(2), .SS_GAP(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .lock0(lock0), .start0(start0), .data_in0(data_in0),
        .gnt0(gnt0), .done0(done0),
        .req1(req1), .lock1(lock1), .start1(start1), .data_in1(data_in1),
        .gnt1(gnt1), .done1(done1),
        .m_start(m_start), .m_data_in(m_data_in), .m_ss(m_ss),
        .m_busy(m_busy), .m_new_data(m_new_data), .m_data_out(m_data_out),
        .rd_data(rd_data), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tick until the named requester is granted, with a 20-cycle bound.
    task automatic wait_gnt(input logic which, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (((which ? gnt1 : gnt0) !== 1'b1) && cnt < 20);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; lock0 = 0; start0 = 0; data_in0 = 8'h00;
        req1 = 0; lock1 = 0; start1 = 0; data_in1 = 8'h00;
        m_busy = 0; m_new_data = 0; m_data_out = 8'hA5;
        tick(); tick();

        // Reset state
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_m_ss", m_ss, 1'b1);
        chk1("rst_m_start", m_start, 1'b0);
        chk8("rst_m_data_in", m_data_in, 8'h00);
        chk1("rst_done0", done0, 1'b0);
        chk1("rst_timeout_err", timeout_err, 1'b0);
        chk8("rd_data_pass", rd_data, 8'hA5);
        rst = 1'b0;

        // Single requester with lock
        req0 = 1; lock0 = 1;
        tick();
        chk1("t1_gnt0", gnt0, 1'b1);
        chk1("t1_gnt1", gnt1, 1'b0);
        chk1("t1_ss_low", m_ss, 1'b0);
        start0 = 1; data_in0 = 8'h5A; #1;
        chk1("t1_setup_start_blocked0", m_start, 1'b0);
        tick();
        chk1("t1_setup_start_blocked1", m_start, 1'b0);
        chk1("t1_setup_ss_low", m_ss, 1'b0);
        tick();
        chk1("t1_active_start", m_start, 1'b1);
        chk8("t1_active_data", m_data_in, 8'h5A);
        start0 = 0; m_busy = 1;
        tick(); tick();
        m_busy = 0; m_new_data = 1; #1;
        chk1("t1_done0", done0, 1'b1);
        chk1("t1_done1_quiet", done1, 1'b0);
        tick();
        m_new_data = 0; #1;
        chk1("t1_done0_pulse", done0, 1'b0);
        req0 = 0; lock0 = 0; #1;
        chk1("t1_gnt_before_release", gnt0, 1'b1);
        tick();
        chk1("t1_release_gnt0", gnt0, 1'b0);
        chk1("t1_release_ss", m_ss, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("t1_gap_ss_high", m_ss, 1'b1);
        end
        tick();

        // Tie after reset, then round-robin
        rst = 1; tick(); rst = 0;
        req0 = 1; req1 = 1;
        tick();
        chk1("t2_tie_gnt0", gnt0, 1'b1);
        chk1("t2_tie_gnt1", gnt1, 1'b0);
        tick(); tick();
        req0 = 0;
        tick();
        chk1("t2_rel0_gnt0", gnt0, 1'b0);
        chk1("t2_rel0_ss", m_ss, 1'b1);
        req0 = 1;
        wait_gnt(1'b1, n);
        chkn("t2_gap_cycles_to_gnt1", n, 5);
        chk1("t2_rr_gnt1", gnt1, 1'b1);
        chk1("t2_rr_gnt0_low", gnt0, 1'b0);
        tick(); tick();
        req1 = 0;
        tick();
        chk1("t2_rel1_gnt1", gnt1, 1'b0);
        req1 = 1;
        wait_gnt(1'b0, n);
        chkn("t2_gap_cycles_to_gnt0", n, 5);
        chk1("t2_rr_back_gnt0", gnt0, 1'b1);
        chk1("t2_rr_back_gnt1_low", gnt1, 1'b0);

        // Isolation of the non-granted requester
        tick(); tick();
        data_in0 = 8'h33; start1 = 1; data_in1 = 8'hFF; m_new_data = 1; #1;
        chk1("t3_start1_blocked", m_start, 1'b0);
        chk8("t3_data_unchanged", m_data_in, 8'h33);
        chk1("t3_done1_quiet", done1, 1'b0);
        chk1("t3_done0", done0, 1'b1);
        tick();
        start1 = 0; m_new_data = 0; lock1 = 1; req0 = 0; #1;
        chk1("t3_done1_still_quiet", done1, 1'b0);
        tick();
        chk1("t3_release_gnt0", gnt0, 1'b0);

        // Multi-byte transfer under lock1
        wait_gnt(1'b1, n);
        chkn("t4_gap_cycles_to_gnt1", n, 5);
        tick(); tick();
        for (int b = 1; b <= 2; b++) begin
            start1 = 1; data_in1 = 8'(b); #1;
            chk1("t4_start", m_start, 1'b1);
            chk8("t4_data", m_data_in, 8'(b));
            tick();
            start1 = 0; req1 = 0; m_busy = 1;
            tick(); tick();
            m_busy = 0; m_new_data = 1; #1;
            chk1("t4_done1", done1, 1'b1);
            chk1("t4_ss_low", m_ss, 1'b0);
            tick();
            m_new_data = 0;
        end
        // Third byte: its start arrives in the cycle lock1 drops and blocks the release
        start1 = 1; data_in1 = 8'h03; lock1 = 0; #1;
        chk1("t4_start3", m_start, 1'b1);
        chk8("t4_data3", m_data_in, 8'h03);
        tick();
        chk1("t4_start_blocks_release", gnt1, 1'b1);
        chk1("t4_ss_still_low", m_ss, 1'b0);
        start1 = 0; m_busy = 1;
        tick(); tick();
        chk1("t4_busy_holds_gnt", gnt1, 1'b1);
        m_busy = 0; m_new_data = 1; #1;
        chk1("t4_done1_in_release_cycle", done1, 1'b1);
        tick();
        m_new_data = 0; #1;
        chk1("t4_release_gnt1", gnt1, 1'b0);
        chk1("t4_release_ss", m_ss, 1'b1);
        chk1("t4_done1_after", done1, 1'b0);

        // Watchdog with TIMEOUT=16
        req0 = 1; lock0 = 1;
        wait_gnt(1'b0, n);
        chkn("t5_gap_cycles_to_gnt0", n, 5);
        tick(); tick();
        repeat (15) tick();
        chk1("t5_gnt0_before_timeout", gnt0, 1'b1);
        chk1("t5_no_err_yet", timeout_err, 1'b0);
        tick();
        chk1("t5_timeout_err", timeout_err, 1'b1);
        chk1("t5_forced_gnt0", gnt0, 1'b0);
        chk1("t5_forced_ss", m_ss, 1'b1);
        req0 = 0; lock0 = 0;
        tick();
        chk1("t5_err_one_cycle", timeout_err, 1'b0);

        // Reset in the middle of a byte
        req1 = 1; lock1 = 1;
        wait_gnt(1'b1, n);
        chkn("t6_gap_cycles_to_gnt1", n, 4);
        tick(); tick();
        start1 = 1; data_in1 = 8'h77;
        tick();
        start1 = 0; m_busy = 1;
        tick();
        rst = 1; req0 = 1; req1 = 1;
        tick();
        chk1("t6_rst_ss", m_ss, 1'b1);
        chk1("t6_rst_gnt1", gnt1, 1'b0);
        chk1("t6_rst_gnt0", gnt0, 1'b0);
        rst = 0; m_busy = 0;
        tick();
        chk1("t6_tie_gnt0", gnt0, 1'b1);
        chk1("t6_tie_gnt1", gnt1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
